sobel_window_gen: RTL and testbench
===================================

SOBEL_WINDOW_GEN -- requirements
Module: sobel_window_gen

Interface
REQ-001 Parameter WIDTH, default 128: image width in pixels, >= 3.
REQ-002 Parameter HEIGHT, default 96: image height in lines, >= 3.
REQ-003 Parameter PIX_W, default 8: pixel bit width.
REQ-004 Parameter BORDER_MODE, default 0: 0 = out-of-image neighbours read as zero; 1 = replicate the nearest edge pixel.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_pix  input  PIX_W  raster-order input pixel.
REQ-008 in_valid  input  1  in_pix valid this cycle.
REQ-009 in_ready  output  1  block accepts in_pix; accept = in_valid & in_ready.
REQ-010 out_valid  output  1  window outputs valid; one-cycle pulse per window, no backpressure.
REQ-011 w0..w8  output  PIX_W each  3x3 window, row-major, w4 = centre.
REQ-012 out_x  output  clog2(WIDTH)  centre column; out_y  output  clog2(HEIGHT)  centre row.
REQ-013 out_edge  output  1  centre lies on the first/last row or column.
REQ-014 frame_done  output  1  pulses together with the last window of a frame.

Function
REQ-015 Internal input index n_in counts accepted pixels 0..WIDTH*HEIGHT-1; it holds during in_valid gaps.
REQ-016 Two line buffers of WIDTH x PIX_W (block RAM) plus a 3x3 register window hold the last two lines and the current line.
REQ-017 The window for centre index c = cy*WIDTH+cx is output one cycle after the event with virtual index c+WIDTH+1.
REQ-018 Virtual indices 0..WIDTH*HEIGHT-1 are input accepts; indices WIDTH*HEIGHT..WIDTH*HEIGHT+WIDTH are drain cycles.
REQ-019 States: FILL (accepting, no output yet), RUN (accepting, emitting), DRAIN (in_ready=0, emitting one window per cycle).
REQ-020 FILL->RUN on accept of index WIDTH; RUN->DRAIN after accept of index WIDTH*HEIGHT-1; DRAIN->FILL after WIDTH+1 drain cycles.
REQ-021 in_ready = 1 in FILL and RUN, 0 in DRAIN.
REQ-022 Exactly WIDTH*HEIGHT windows per frame, centres in raster order (0,0)..(WIDTH-1,HEIGHT-1).
REQ-023 Neighbours with x<0, x>=WIDTH, y<0 or y>=HEIGHT take 0 (BORDER_MODE=0) or the clamped-coordinate pixel (BORDER_MODE=1); row-wrap data never appears in a window.
REQ-024 out_edge = (cx==0)|(cx==WIDTH-1)|(cy==0)|(cy==HEIGHT-1), registered with out_valid.
REQ-025 w0..w8, out_x, out_y, out_edge hold their last value while out_valid=0.
REQ-026 The next frame's first accept may occur in the cycle after DRAIN exits; frames are back-to-back capable.

Reset
REQ-027 While rst=1: state=FILL, counters=0, out_valid=0, frame_done=0, out_edge=0, w0..w8=0, out_x=out_y=0, in_ready=0.
REQ-028 in_ready=1 in the first cycle after rst deasserts.
REQ-029 rst mid-frame or mid-drain discards the partial frame; the first accept after reset is pixel (0,0); line-buffer contents need no clearing.

Verification (WIDTH=4, HEIGHT=3, PIX_W=8, in_pix = index 0..11)
REQ-030 Centre (1,1): one cycle after accept of index 10, w0..w8 = 0,1,2,4,5,6,8,9,10, out_edge=0.
REQ-031 Corner (0,0), BORDER_MODE=0: one cycle after accept of index 5, window = 0,0,0,0,0,1,0,4,5, out_edge=1; BORDER_MODE=1: 0,0,1,0,0,1,4,4,5.
REQ-032 Drain: after accept of index 11, in_ready=0 for exactly 5 cycles; out_valid high on 5 consecutive cycles for centres 7..11; frame_done together with centre (3,2); total 12 windows.
REQ-033 Random in_valid gaps (50 %): window sequence identical to the gap-free run; no out_valid during gap cycles in FILL/RUN except for the one-cycle-delayed window.
REQ-034 rst asserted after 7 accepts, then a full frame: outputs match a fresh-frame reference; no window contains pre-reset data.
REQ-035 Two back-to-back frames (second = index+100): second frame's centre (1,1) window = 100,101,102,104,105,106,108,109,110.

Source files
------------

// File: rtl/sobel_window_gen.sv
// 3x3 Sobel neighbourhood generator: raster pixels in, one bordered window per pixel out.
// Latency: window for centre c appears one cycle after the accept (or drain cycle) of index c+WIDTH+1.
// Backpressure: in_ready drops for WIDTH+1 drain cycles at frame end; outputs cannot be stalled.
module sobel_window_gen #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 96,
    parameter int PIX_W       = 8,
    parameter int BORDER_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_W-1:0]          in_pix,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [PIX_W-1:0]          w0,
    output logic [PIX_W-1:0]          w1,
    output logic [PIX_W-1:0]          w2,
    output logic [PIX_W-1:0]          w3,
    output logic [PIX_W-1:0]          w4,
    output logic [PIX_W-1:0]          w5,
    output logic [PIX_W-1:0]          w6,
    output logic [PIX_W-1:0]          w7,
    output logic [PIX_W-1:0]          w8,
    output logic [$clog2(WIDTH)-1:0]  out_x,
    output logic [$clog2(HEIGHT)-1:0] out_y,
    output logic                      out_edge,
    output logic                      frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    // Virtual row counter runs past the image by two rows to cover the drain cycles.
    localparam int RW = $clog2(HEIGHT + 2);

    localparam logic [XW-1:0] LAST_X      = XW'(WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y      = YW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE     = RW'(1);
    localparam logic [RW-1:0] ROW_LAST_IN = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_END     = RW'(HEIGHT + 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t           state;
    logic             ready_q;
    logic [XW-1:0]    vcol, vcol_nxt;
    logic [RW-1:0]    vrow, vrow_nxt;
    logic             accept, event_go, emit, last_win;

    // Line buffers: lb0 holds the previous line, lb1 the line before that.
    logic [PIX_W-1:0] lb0 [WIDTH];
    logic [PIX_W-1:0] lb1 [WIDTH];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;

    // Raw window columns (index 0 = top row), unmasked.
    logic [PIX_W-1:0] win_l [3];
    logic [PIX_W-1:0] win_m [3];
    logic [PIX_W-1:0] win_r [3];
    logic [PIX_W-1:0] col_new [3];

    logic [XW-1:0]    cx;
    logic [YW-1:0]    cy;
    logic             left_ok, right_ok, top_ok, bot_ok, edge_nxt;
    logic [PIX_W-1:0] hl [3];
    logic [PIX_W-1:0] hm [3];
    logic [PIX_W-1:0] hr [3];
    logic [PIX_W-1:0] nw [9];
    logic [PIX_W-1:0] w_q [9];

    assign in_ready = ready_q & ~rst;
    assign accept   = in_valid & in_ready;
    // Every accept and every drain cycle advances the virtual index by one.
    assign event_go = accept | (state == DRAIN);
    assign emit     = ((state == RUN) & accept) | (state == DRAIN);
    assign last_win = (state == DRAIN) && (vrow == ROW_END);

    assign col_new[0] = lb1_rd;
    assign col_new[1] = lb0_rd;
    assign col_new[2] = in_pix;

    // Next virtual column/row; also drives the line-buffer read address one cycle ahead.
    always_comb begin
        vcol_nxt = vcol;
        vrow_nxt = vrow;
        if (rst || last_win) begin
            vcol_nxt = '0;
            vrow_nxt = '0;
        end else if (event_go) begin
            if (vcol == LAST_X) begin
                vcol_nxt = '0;
                vrow_nxt = vrow + RW'(1);
            end else begin
                vcol_nxt = vcol + XW'(1);
            end
        end
    end

    // Centre lags the newest column by one: column 0 means the centre closed the previous row.
    always_comb begin
        if (vcol == '0) begin
            cx = LAST_X;
            cy = YW'(vrow - RW'(2));
        end else begin
            cx = vcol - XW'(1);
            cy = YW'(vrow - RW'(1));
        end
    end

    assign left_ok  = (cx != '0);
    assign right_ok = (cx != LAST_X);
    assign top_ok   = (cy != '0);
    assign bot_ok   = (cy != LAST_Y);
    assign edge_nxt = ~left_ok | ~right_ok | ~top_ok | ~bot_ok;

    // Border handling on the post-shift window; wrapped or stale data is always replaced.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            hm[r] = win_r[r];
            hl[r] = left_ok  ? win_m[r]   : ((BORDER_MODE != 0) ? win_r[r] : '0);
            hr[r] = right_ok ? col_new[r] : ((BORDER_MODE != 0) ? win_r[r] : '0);
        end
        nw[0] = top_ok ? hl[0] : ((BORDER_MODE != 0) ? hl[1] : '0);
        nw[1] = top_ok ? hm[0] : ((BORDER_MODE != 0) ? hm[1] : '0);
        nw[2] = top_ok ? hr[0] : ((BORDER_MODE != 0) ? hr[1] : '0);
        nw[3] = hl[1];
        nw[4] = hm[1];
        nw[5] = hr[1];
        nw[6] = bot_ok ? hl[2] : ((BORDER_MODE != 0) ? hl[1] : '0);
        nw[7] = bot_ok ? hm[2] : ((BORDER_MODE != 0) ? hm[1] : '0);
        nw[8] = bot_ok ? hr[2] : ((BORDER_MODE != 0) ? hr[1] : '0);
    end

    // Line buffers: registered read of the next column, cascade write on accept.
    always_ff @(posedge clk) begin
        lb0_rd <= lb0[vcol_nxt];
        lb1_rd <= lb1[vcol_nxt];
        if (accept) begin
            lb0[vcol] <= in_pix;
            lb1[vcol] <= lb0_rd;
        end
    end

    // Frame sequencing: FILL until two lines are in, RUN while accepting, DRAIN to flush the last row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            ready_q <= 1'b1;
            vcol    <= '0;
            vrow    <= '0;
        end else begin
            vcol <= vcol_nxt;
            vrow <= vrow_nxt;
            case (state)
                FILL: begin
                    if (accept && (vrow == ROW_ONE) && (vcol == '0)) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept && (vrow == ROW_LAST_IN) && (vcol == LAST_X)) begin
                        state   <= DRAIN;
                        ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (last_win) begin
                        state   <= FILL;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= FILL;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Raw window shift: one new column per virtual event.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                win_l[r] <= '0;
                win_m[r] <= '0;
                win_r[r] <= '0;
            end
        end else if (event_go) begin
            win_l <= win_m;
            win_m <= win_r;
            win_r <= col_new;
        end
    end

    // Output registers: load on each emitted window, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_edge   <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            for (int k = 0; k < 9; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            out_valid  <= emit;
            frame_done <= last_win;
            if (emit) begin
                w_q      <= nw;
                out_x    <= cx;
                out_y    <= cy;
                out_edge <= edge_nxt;
            end
        end
    end

    assign w0 = w_q[0];
    assign w1 = w_q[1];
    assign w2 = w_q[2];
    assign w3 = w_q[3];
    assign w4 = w_q[4];
    assign w5 = w_q[5];
    assign w6 = w_q[6];
    assign w7 = w_q[7];
    assign w8 = w_q[8];

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen at 4x3: two instances (zero and replicate borders) share stimulus.
// Each window is checked on the exact cycle it is due against a coordinate-based image model.
// Random in_valid gaps, random pixels, mid-frame/mid-drain resets and back-to-back frames.
module tb_sobel_window_gen;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_pix;
    logic             in_valid;
    logic             rdy0, rdy1, ov0, ov1, edge0, edge1, fd0, fd1;
    logic [8:0][7:0]  wa, wb;
    logic [1:0]       x0, x1, y0, y1;

    always #5 clk = ~clk;

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .BORDER_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_ready(rdy0),
        .out_valid(ov0),
        .w0(wa[0]), .w1(wa[1]), .w2(wa[2]), .w3(wa[3]), .w4(wa[4]),
        .w5(wa[5]), .w6(wa[6]), .w7(wa[7]), .w8(wa[8]),
        .out_x(x0), .out_y(y0), .out_edge(edge0), .frame_done(fd0)
    );

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .BORDER_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_pix(in_pix), .in_valid(in_valid), .in_ready(rdy1),
        .out_valid(ov1),
        .w0(wb[0]), .w1(wb[1]), .w2(wb[2]), .w3(wb[3]), .w4(wb[4]),
        .w5(wb[5]), .w6(wb[6]), .w7(wb[7]), .w8(wb[8]),
        .out_x(x1), .out_y(y1), .out_edge(edge1), .frame_done(fd1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          nwin;
    logic [7:0]  img [N];
    logic [71:0] cap0 [N];
    logic [71:0] cap1 [N];
    logic [71:0] hold0, hold1;
    logic [4:0]  holdm;

    // Reference pixel at (x,y) of the current frame under the given border rule.
    function automatic logic [7:0] ref_pix(input int mode, input int x, input int y);
        int xx, yy;
        if (x >= 0 && x < W && y >= 0 && y < H) return img[y * W + x];
        if (mode == 0) return 8'd0;
        xx = (x < 0) ? 0 : ((x >= W) ? W - 1 : x);
        yy = (y < 0) ? 0 : ((y >= H) ? H - 1 : y);
        return img[yy * W + xx];
    endfunction

    // Reference 3x3 window around centre index c, w0 in the low byte.
    function automatic logic [71:0] ref_win(input int mode, input int c);
        logic [71:0] r;
        int cx, cy;
        cx = c % W;
        cy = c / W;
        r  = '0;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                r[(dy * 3 + dx) * 8 +: 8] = ref_pix(mode, cx + dx - 1, cy + dy - 1);
        return r;
    endfunction

    // Streams one frame (pat<0: random pixels, else pat+index); every cycle checks timing and data.
    task automatic run_frame(input int pat, input int gap_pct, input int stop_after);
        int   n, dr, evs, vidx, c, cx, cy;
        logic ev, emit, drv, exp_rdy, dn;
        n = 0; dr = 0; evs = 0;
        for (int k = 0; k < N; k++) img[k] = (pat < 0) ? 8'($urandom) : 8'(pat + k);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            drv  = int'($urandom_range(99)) >= gap_pct;
            ev   = 1'b0;
            vidx = 0;
            if (n < N) begin
                in_valid = drv;
                in_pix   = drv ? img[n] : 8'($urandom);
                if (drv) begin
                    vidx = n; n++; ev = 1'b1;
                end
            end else begin
                // Drain: keep presenting junk so a leaky in_ready would corrupt the stream.
                in_valid = drv;
                in_pix   = 8'($urandom);
                vidx = N + dr; dr++; ev = 1'b1;
            end
            emit = ev && (vidx >= W + 1);
            c    = vidx - W - 1;
            dn   = emit && (c == N - 1);
            if (emit) begin
                cx    = c % W;
                cy    = c / W;
                hold0 = ref_win(0, c);
                hold1 = ref_win(1, c);
                holdm = {2'(cx), 2'(cy), (cx == 0 || cx == W - 1 || cy == 0 || cy == H - 1)};
            end
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({ov0, fd0, ov1, fd1} !== {emit, dn, emit, dn}) begin
                n_err++;
                $display("FAIL valid_done vidx=%0d got=%b exp=%b", vidx, {ov0, fd0, ov1, fd1}, {emit, dn, emit, dn});
            end
            n_vec++;
            if (wa !== hold0) begin
                n_err++;
                $display("FAIL window_zero c=%0d got=%h exp=%h", c, wa, hold0);
            end
            n_vec++;
            if (wb !== hold1) begin
                n_err++;
                $display("FAIL window_repl c=%0d got=%h exp=%h", c, wb, hold1);
            end
            n_vec++;
            if ({x0, y0, edge0} !== holdm || {x1, y1, edge1} !== holdm) begin
                n_err++;
                $display("FAIL meta c=%0d got=%b/%b exp=%b", c, {x0, y0, edge0}, {x1, y1, edge1}, holdm);
            end
            if (emit) begin
                cap0[c] = wa;
                cap1[c] = wb;
                nwin++;
            end
            exp_rdy = (n < N) || (dr == W + 1);
            n_vec++;
            if ({rdy0, rdy1} !== {exp_rdy, exp_rdy}) begin
                n_err++;
                $display("FAIL in_ready n=%0d dr=%0d got=%b exp=%b", n, dr, {rdy0, rdy1}, {exp_rdy, exp_rdy});
            end
            if (ev) evs++;
            if ((stop_after > 0 && evs == stop_after) || dr == W + 1) begin
                in_valid = 1'b0;
                return;
            end
        end
        n_err++;
        $display("FAIL frame_timeout n=%0d dr=%0d required drain=%0d", n, dr, W + 1);
        in_valid = 1'b0;
    endtask

    task automatic test_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if ({wa, wb, x0, y0, x1, y1, edge0, edge1, ov0, ov1, fd0, fd1, rdy0, rdy1} !== '0) begin
                n_err++;
                $display("FAIL reset_state got wa=%h wb=%h x=%0d/%0d y=%0d/%0d e=%b%b v=%b%b fd=%b%b rdy=%b%b exp all zero",
                         wa, wb, x0, x1, y0, y1, edge0, edge1, ov0, ov1, fd0, fd1, rdy0, rdy1);
            end
        end
        hold0 = '0;
        hold1 = '0;
        holdm = '0;
        rst   = 1'b0;
        #1;
        n_vec++;
        if ({rdy0, rdy1} !== 2'b11) begin
            n_err++;
            $display("FAIL ready_after_reset got=%b exp=11", {rdy0, rdy1});
        end
    endtask

    task automatic test_gap_free();
        int          e_c[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int          e_z[9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
        int          e_r[9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
        logic [71:0] ec, ez, er;
        for (int k = 0; k < 9; k++) begin
            ec[k * 8 +: 8] = 8'(e_c[k]);
            ez[k * 8 +: 8] = 8'(e_z[k]);
            er[k * 8 +: 8] = 8'(e_r[k]);
        end
        nwin = 0;
        run_frame(0, 0, 0);
        n_vec++;
        if (cap0[5] !== ec || cap1[5] !== ec) begin
            n_err++;
            $display("FAIL centre_1_1 got=%h/%h exp=%h", cap0[5], cap1[5], ec);
        end
        n_vec++;
        if (cap0[0] !== ez) begin
            n_err++;
            $display("FAIL corner_zero got=%h exp=%h", cap0[0], ez);
        end
        n_vec++;
        if (cap1[0] !== er) begin
            n_err++;
            $display("FAIL corner_repl got=%h exp=%h", cap1[0], er);
        end
        n_vec++;
        if (nwin != N) begin
            n_err++;
            $display("FAIL window_count got=%0d exp=%0d", nwin, N);
        end
    endtask

    task automatic test_random_gaps();
        for (int f = 0; f < 4; f++) begin
            nwin = 0;
            run_frame((f == 0) ? 0 : -1, 50, 0);
            n_vec++;
            if (nwin != N) begin
                n_err++;
                $display("FAIL gap_window_count frame=%0d got=%0d exp=%0d", f, nwin, N);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(200, 0, 7);
        test_reset(2);
        nwin = 0;
        run_frame(0, 30, 0);
        n_vec++;
        if (nwin != N) begin
            n_err++;
            $display("FAIL post_reset_count got=%0d exp=%0d", nwin, N);
        end
    endtask

    task automatic test_reset_mid_drain();
        run_frame(-1, 0, N + 2);
        test_reset(1);
        nwin = 0;
        run_frame(-1, 20, 0);
        n_vec++;
        if (nwin != N) begin
            n_err++;
            $display("FAIL post_drain_reset_count got=%0d exp=%0d", nwin, N);
        end
    endtask

    task automatic test_back_to_back();
        int          e_c[9] = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        logic [71:0] ec;
        for (int k = 0; k < 9; k++) ec[k * 8 +: 8] = 8'(e_c[k]);
        run_frame(0, 0, 0);
        nwin = 0;
        run_frame(100, 0, 0);
        n_vec++;
        if (cap0[5] !== ec || cap1[5] !== ec) begin
            n_err++;
            $display("FAIL b2b_centre got=%h/%h exp=%h", cap0[5], cap1[5], ec);
        end
        n_vec++;
        if (nwin != N) begin
            n_err++;
            $display("FAIL b2b_count got=%0d exp=%0d", nwin, N);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_pix   = '0;
        hold0    = '0;
        hold1    = '0;
        holdm    = '0;
        nwin     = 0;
        @(negedge clk);
        test_reset(3);
        test_gap_free();
        test_random_gaps();
        test_reset_mid_frame();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
